// File: rtl/multi_channel_bar_array_pkg.sv
// Shared types and width helpers for the multi-channel level-to-bar converter.
package multi_channel_bar_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        OUT   = 2'd2
    } state_e;

    localparam logic MODE_BAR = 1'b0;
    localparam logic MODE_DOT = 1'b1;

    function automatic int unsigned ch_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int unsigned lv_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multi_channel_bar_array_peak_fall_tracker.sv
// One channel's peak-hold / peak-fall state; peak_next_c_o is the peak after this cycle's update.
module peak_fall_tracker
    import multi_channel_bar_array_pkg::*;
#(
    parameter int unsigned LV_W            = 6,
    parameter int unsigned PEAK_HOLD_COUNT = 1000,
    parameter int unsigned PEAK_FALL_DIV   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            update_i,
    input  logic [LV_W-1:0] level_i,
    output logic [LV_W-1:0] peak_next_c_o
);

    localparam int unsigned HOLD_W = $clog2(PEAK_HOLD_COUNT + 1);
    localparam int unsigned FALL_W = (PEAK_FALL_DIV > 1) ? $clog2(PEAK_FALL_DIV) : 1;

    logic [LV_W-1:0]   peak_q, peak_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [FALL_W-1:0] fall_q, fall_d;
    logic [LV_W-1:0]   peak_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q <= '0;
            hold_q <= '0;
            fall_q <= '0;
        end else begin
            peak_q <= peak_d;
            hold_q <= hold_d;
            fall_q <= fall_d;
        end
    end

    // Decrements are guarded by !=0 checks, so no counter can wrap.
    always_comb begin
        peak_d   = peak_q;
        hold_d   = hold_q;
        fall_d   = fall_q;
        peak_dec = peak_q - LV_W'(1);
        if (update_i) begin
            if (level_i >= peak_q) begin
                peak_d = level_i;
                hold_d = HOLD_W'(PEAK_HOLD_COUNT);
                fall_d = FALL_W'(PEAK_FALL_DIV - 1);
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end else if (fall_q != '0) begin
                fall_d = fall_q - FALL_W'(1);
            end else begin
                peak_d = (peak_dec > level_i) ? peak_dec : level_i;
                fall_d = FALL_W'(PEAK_FALL_DIV - 1);
            end
        end
    end

    assign peak_next_c_o = peak_d;

endmodule

// File: rtl/multi_channel_bar_array.sv
// Multi-channel level meter: per-channel peak tracking, serial bar/dot pattern build,
// valid/ready output toward the display driver.
module multi_channel_bar_array
    import multi_channel_bar_array_pkg::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned CHANNELS        = 2,
    parameter int unsigned PEAK_HOLD_COUNT = 1000,
    parameter int unsigned PEAK_FALL_DIV   = 8,
    localparam int unsigned CH_W           = ch_width(CHANNELS),
    localparam int unsigned LV_W           = lv_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [CH_W-1:0]  i_channel,
    input  logic [LV_W-1:0]  i_position,
    input  logic             i_mode,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [CH_W-1:0]  o_channel,
    output logic [WIDTH-1:0] o_array
);

    localparam int unsigned K_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [WIDTH-1:0]  array_q, array_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [LV_W-1:0]   level_q, level_d;
    logic [LV_W-1:0]   peak_q, peak_d;
    logic              mode_q, mode_d;
    logic              i_ready_q, i_ready_d;
    logic              o_valid_q, o_valid_d;

    logic              accept_c;
    logic              chan_ok_c;
    logic [LV_W-1:0]   level_clamp_c;
    logic [LV_W-1:0]   sel_peak_c;
    logic [LV_W-1:0]   kk_c;
    logic              seg_bit_c;
    logic [LV_W-1:0]   peak_next [CHANNELS];

    assign accept_c      = i_valid && i_ready_q;
    assign chan_ok_c     = 32'(i_channel) < CHANNELS;
    assign level_clamp_c = (32'(i_position) > WIDTH) ? LV_W'(WIDTH) : i_position;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_trk
        peak_fall_tracker #(
            .LV_W            (LV_W),
            .PEAK_HOLD_COUNT (PEAK_HOLD_COUNT),
            .PEAK_FALL_DIV   (PEAK_FALL_DIV)
        ) u_trk (
            .clk           (clk),
            .reset         (reset),
            .update_i      (accept_c && (i_channel == CH_W'(g))),
            .level_i       (level_clamp_c),
            .peak_next_c_o (peak_next[g])
        );
    end

    // Post-update peak of the addressed channel.
    always_comb begin
        sel_peak_c = '0;
        for (int unsigned g = 0; g < CHANNELS; g++) begin
            if (i_channel == CH_W'(g)) sel_peak_c = peak_next[g];
        end
    end

    // Segment k of the pattern being built.
    always_comb begin
        kk_c      = LV_W'(k_q);
        seg_bit_c = (peak_q != '0) && (kk_c == peak_q - LV_W'(1));
        if (mode_q == MODE_BAR) begin
            seg_bit_c = seg_bit_c || (kk_c < level_q);
        end else begin
            seg_bit_c = seg_bit_c || ((level_q != '0) && (kk_c == level_q - LV_W'(1)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            array_q   <= '0;
            chan_q    <= '0;
            level_q   <= '0;
            peak_q    <= '0;
            mode_q    <= MODE_BAR;
            i_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            array_q   <= array_d;
            chan_q    <= chan_d;
            level_q   <= level_d;
            peak_q    <= peak_d;
            mode_q    <= mode_d;
            i_ready_q <= i_ready_d;
            o_valid_q <= o_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        array_d   = array_q;
        chan_d    = chan_q;
        level_d   = level_q;
        peak_d    = peak_q;
        mode_d    = mode_q;
        o_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Out-of-range channels are swallowed without leaving IDLE.
                if (accept_c && chan_ok_c) begin
                    state_d = BUILD;
                    k_d     = '0;
                    chan_d  = i_channel;
                    level_d = level_clamp_c;
                    peak_d  = sel_peak_c;
                    mode_d  = i_mode;
                end
            end
            BUILD: begin
                array_d = {seg_bit_c, array_q[WIDTH-1:1]};
                k_d     = k_q + K_W'(1);
                if (k_q == K_W'(WIDTH - 1)) state_d = OUT;
            end
            OUT: begin
                o_valid_d = 1'b1;
                if (o_valid_q && o_ready) begin
                    state_d   = IDLE;
                    o_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        i_ready_d = (state_d == IDLE);
    end

    assign i_ready   = i_ready_q;
    assign o_valid   = o_valid_q;
    assign o_channel = chan_q;
    assign o_array   = array_q;

endmodule
